// File: rtl/aes_stream_pkg.sv
// Shared types and defaults for the AES-128 word-stream adapter.
// Holds the state encoding, the word-index type and the default abort timeout.
package aes_stream_pkg;

   typedef enum logic [1:0] {
      StCollect = 2'd0,
      StLaunch  = 2'd1,
      StWait    = 2'd2,
      StDrain   = 2'd3
   } state_e;

   typedef logic [1:0] word_idx_t;

   localparam int unsigned TimeoutCycDefault = 1023;

endpackage

// File: rtl/aes_stream_adapter_if.sv
// 32-bit valid/ready word stream used on both sides of the adapter.
// The last flag is meaningful only on the output side.
interface aes_stream_adapter_if;

   logic        valid;
   logic        ready;
   logic [31:0] data;
   logic        last;

   modport master (
      output valid,
      output data,
      output last,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );

endinterface

// File: rtl/aes_word_unpacker.sv
// Serialises one 128-bit block into four 32-bit words, bits [127:96] first.
// The block is shifted up on each handshake so m_data always reads the top word.
module aes_word_unpacker
   import aes_stream_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        load_i,
   input  logic [127:0]                block_i,
   output logic                        done_o,
   aes_stream_adapter_if.master        m_if
);

   logic [127:0] buf_q, buf_d;
   word_idx_t    idx_q, idx_d;
   logic         valid_q, valid_d;
   logic         hs;

   assign hs     = valid_q & m_if.ready;
   assign done_o = hs & (idx_q == 2'd3);

   always_comb begin
      buf_d   = buf_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      if (load_i) begin
         buf_d   = block_i;
         idx_d   = '0;
         valid_d = 1'b1;
      end else if (hs) begin
         buf_d = {buf_q[95:0], 32'h0};
         idx_d = idx_q + 2'd1;
         if (idx_q == 2'd3) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         buf_q   <= buf_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

   assign m_if.valid = valid_q;
   assign m_if.data  = buf_q[127:96];
   assign m_if.last  = valid_q & (idx_q == 2'd3);

endmodule

// File: rtl/aes_stream_adapter.sv
// Packs four 32-bit input words into an AES-128 block, runs it through an external core
// and streams the 128-bit result back out as four words, with a WAIT-state abort timer.
module aes_stream_adapter
   import aes_stream_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 key_wr,
   input  logic [127:0]         key_data,
   input  logic                 mode_dec,
   aes_stream_adapter_if.slave  s_if,
   aes_stream_adapter_if.master m_if,
   output logic                 core_start,
   output logic                 core_decrypt,
   output logic [127:0]         core_data,
   output logic [127:0]         core_key,
   input  logic                 core_ready,
   input  logic [127:0]         core_result,
   output logic                 busy,
   output logic                 timeout_err,
   input  logic                 err_clr
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT_CYC - 1);

   state_e          state_q, state_d;
   word_idx_t       cnt_q, cnt_d;
   logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
   logic [127:0]    data_q, data_d;
   logic [127:0]    key_q, key_d;
   logic            dec_q, dec_d;
   logic            start_q, start_d;
   logic            s_ready_q, s_ready_d;
   logic            busy_q, busy_d;
   logic            err_q, err_d;
   logic            unp_load;
   logic            unp_done;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wait_cnt_d = wait_cnt_q;
      data_d     = data_q;
      key_d      = key_q;
      dec_d      = dec_q;
      start_d    = 1'b0;
      err_d      = err_q & ~err_clr;
      unp_load   = 1'b0;

      unique case (state_q)
         StCollect: begin
            if (key_wr && (cnt_q == '0)) begin
               key_d = key_data;
            end
            if (s_if.valid && s_ready_q) begin
               // Word n lands at bit offset (3-n)*32; ~cnt_q equals 3-cnt_q.
               data_d[{~cnt_q, 5'd0} +: 32] = s_if.data;
               if (cnt_q == '0) begin
                  dec_d = mode_dec;
               end
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = StLaunch;
                  start_d = 1'b1;
               end
            end
         end
         StLaunch: begin
            state_d    = StWait;
            wait_cnt_d = '0;
         end
         StWait: begin
            if (core_ready) begin
               unp_load = 1'b1;
               state_d  = StDrain;
            end else if (wait_cnt_q == WaitLast) begin
               // A set in the same cycle as err_clr wins.
               err_d   = 1'b1;
               state_d = StCollect;
               cnt_d   = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + CntW'(1);
            end
         end
         StDrain: begin
            if (unp_done) begin
               state_d = StCollect;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = StCollect;
            cnt_d   = '0;
         end
      endcase

      s_ready_d = (state_d == StCollect);
      busy_d    = !((state_d == StCollect) && (cnt_d == '0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StCollect;
         cnt_q      <= '0;
         wait_cnt_q <= '0;
         data_q     <= '0;
         key_q      <= '0;
         dec_q      <= 1'b0;
         start_q    <= 1'b0;
         s_ready_q  <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wait_cnt_q <= wait_cnt_d;
         data_q     <= data_d;
         key_q      <= key_d;
         dec_q      <= dec_d;
         start_q    <= start_d;
         s_ready_q  <= s_ready_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   aes_word_unpacker u_unpacker (
      .clk     (clk),
      .rst     (rst),
      .load_i  (unp_load),
      .block_i (core_result),
      .done_o  (unp_done),
      .m_if    (m_if)
   );

   assign s_if.ready   = s_ready_q;
   assign core_start   = start_q;
   assign core_decrypt = dec_q;
   assign core_data    = data_q;
   assign core_key     = key_q;
   assign busy         = busy_q;
   assign timeout_err  = err_q;

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Directed bench for aes_stream_adapter using FIPS-197 AES-128 vectors and a stub core.
`timescale 1ns/1ps
module tb_aes_stream_adapter;

   localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         rst;
   logic         key_wr;
   logic [127:0] key_data;
   logic         mode_dec;
   logic         core_start;
   logic         core_decrypt;
   logic [127:0] core_data;
   logic [127:0] core_key;
   logic         core_ready;
   logic [127:0] core_result;
   logic         busy;
   logic         timeout_err;
   logic         err_clr;

   int errors = 0;
   int checks = 0;
   int start_cnt = 0;
   bit mvalid_seen = 1'b0;

   aes_stream_adapter_if s_if ();
   aes_stream_adapter_if m_if ();

   aes_stream_adapter #(.TIMEOUT_CYC(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .key_wr       (key_wr),
      .key_data     (key_data),
      .mode_dec     (mode_dec),
      .s_if         (s_if),
      .m_if         (m_if),
      .core_start   (core_start),
      .core_decrypt (core_decrypt),
      .core_data    (core_data),
      .core_key     (core_key),
      .core_ready   (core_ready),
      .core_result  (core_result),
      .busy         (busy),
      .timeout_err  (timeout_err),
      .err_clr      (err_clr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (core_start) start_cnt++;
      if (m_if.valid) mvalid_seen = 1'b1;
   end

   // Drives one block; mode_dec is inverted after the first word to exercise latching.
   task automatic send_block(input logic [127:0] blk, input logic dec, input int kw_at,
                             output bit ok);
      int n;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_if.valid = 1'b1;
         s_if.data  = blk[127-32*i -: 32];
         mode_dec   = (i == 0) ? dec : ~dec;
         key_wr     = (i == kw_at);
         key_data   = ~KEY;
         n = 0;
         while (!s_if.ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (!s_if.ready) ok = 1'b0;
         @(negedge clk);
         key_wr = 1'b0;
      end
      s_if.valid = 1'b0;
      mode_dec   = 1'b0;
   endtask

   task automatic wait_start(output bit ok);
      int n = 0;
      while (!core_start && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = core_start;
   endtask

   task automatic serve_core(input logic [127:0] res, output bit ok, output logic [127:0] d,
                             output logic [127:0] k, output logic dc, output bit stable);
      wait_start(ok);
      d = core_data;
      k = core_key;
      dc = core_decrypt;
      repeat (2) @(negedge clk);
      stable = (core_data === d) && (core_key === k) && (core_decrypt === dc);
      core_ready  = 1'b1;
      core_result = res;
      @(negedge clk);
      core_ready  = 1'b0;
      core_result = '0;
   endtask

   task automatic drain(input logic [3:0] pat, output logic [127:0] got, output logic [3:0] lst,
                        output int nhs, output bit held_ok, output bit srdy_ok,
                        output bit srdy_after);
      int k = 0;
      bit stalled = 1'b0;
      bit after_pending = 1'b0;
      logic [31:0] prev = '0;
      got = '0; lst = '0; nhs = 0; held_ok = 1'b1; srdy_ok = 1'b1; srdy_after = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (after_pending) begin
            srdy_after = s_if.ready;
            after_pending = 1'b0;
         end
         if (stalled && (!m_if.valid || m_if.data !== prev)) held_ok = 1'b0;
         if (nhs < 4 && s_if.ready) srdy_ok = 1'b0;
         m_if.ready = (m_if.valid && k < 4) ? pat[k] : 1'b1;
         if (m_if.valid) k++;
         if (m_if.valid && m_if.ready) begin
            if (nhs < 4) begin
               got[127-32*nhs -: 32] = m_if.data;
               lst[nhs] = m_if.last;
            end
            nhs++;
            if (nhs == 4) after_pending = 1'b1;
         end
         stalled = m_if.valid && !m_if.ready;
         prev = m_if.data;
         @(negedge clk);
      end
      m_if.ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({s_if.ready, m_if.valid, m_if.last, core_start, core_decrypt, busy, timeout_err}
          !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000000", {s_if.ready, m_if.valid,
                  m_if.last, core_start, core_decrypt, busy, timeout_err});
      end
      checks++;
      if (m_if.data !== 32'h0) begin
         errors++; $display("FAIL reset_m_data: got %h expected 0", m_if.data);
      end
      checks++;
      if (core_data !== 128'h0 || core_key !== 128'h0) begin
         errors++; $display("FAIL reset_core_bus: got %h/%h expected 0", core_data, core_key);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (s_if.ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_release: s_ready/busy got %b%b expected 10",
                            s_if.ready, busy);
      end
   endtask

   task automatic test_encrypt();
      bit ok1, ok2, stable, held, srdy, after;
      logic [127:0] d, k, got;
      logic dc;
      logic [3:0] lst;
      int nhs, s0;
      key_wr = 1'b1; key_data = KEY;
      @(negedge clk);
      key_wr = 1'b0;
      s0 = start_cnt;
      send_block(PT, 1'b0, -1, ok1);
      serve_core(CT, ok2, d, k, dc, stable);
      checks++;
      if (!(ok1 && ok2)) begin
         errors++; $display("FAIL enc_handshake: got %b%b expected 11", ok1, ok2);
      end
      checks++;
      if (d !== PT || k !== KEY || dc !== 1'b0) begin
         errors++; $display("FAIL enc_core_in: got %h %h %b expected %h %h 0", d, k, dc, PT, KEY);
      end
      checks++;
      if (!stable || busy !== 1'b1) begin
         errors++; $display("FAIL enc_stable_busy: got %b%b expected 11", stable, busy);
      end
      drain(4'b1111, got, lst, nhs, held, srdy, after);
      checks++;
      if (got !== CT) begin
         errors++; $display("FAIL enc_m_data: got %h expected %h", got, CT);
      end
      checks++;
      if (lst !== 4'b1000 || nhs != 4) begin
         errors++; $display("FAIL enc_last_count: got %b/%0d expected 1000/4", lst, nhs);
      end
      checks++;
      if (!after || busy !== 1'b0 || start_cnt - s0 != 1) begin
         errors++; $display("FAIL enc_return: s_ready/busy/starts got %b%b%0d expected 101",
                            after, busy, start_cnt - s0);
      end
   endtask

   task automatic test_decrypt();
      bit ok1, ok2, stable, held, srdy, after;
      logic [127:0] d, k, got;
      logic dc;
      logic [3:0] lst;
      int nhs, s0;
      s0 = start_cnt;
      send_block(CT, 1'b1, -1, ok1);
      serve_core(PT, ok2, d, k, dc, stable);
      checks++;
      if (d !== CT || dc !== 1'b1 || k !== KEY) begin
         errors++; $display("FAIL dec_core_in: got %h %b %h expected %h 1 %h", d, dc, k, CT, KEY);
      end
      drain(4'b1111, got, lst, nhs, held, srdy, after);
      checks++;
      if (got !== PT || lst !== 4'b1000) begin
         errors++; $display("FAIL dec_m_data: got %h/%b expected %h/1000", got, lst, PT);
      end
      checks++;
      if (start_cnt - s0 != 1 || !(ok1 && ok2 && stable)) begin
         errors++; $display("FAIL dec_start_once: got %0d pulses expected 1", start_cnt - s0);
      end
   endtask

   task automatic test_backpressure();
      bit ok1, ok2, stable, held, srdy, after;
      logic [127:0] d, k, got;
      logic dc;
      logic [3:0] lst;
      int nhs;
      send_block(PT, 1'b0, 2, ok1);
      serve_core(CT, ok2, d, k, dc, stable);
      checks++;
      if (k !== KEY || !(ok1 && ok2)) begin
         errors++; $display("FAIL bp_key_ignored: got %h expected %h", k, KEY);
      end
      drain(4'b1001, got, lst, nhs, held, srdy, after);
      checks++;
      if (!held) begin
         errors++; $display("FAIL bp_hold: got changed word expected held word");
      end
      checks++;
      if (nhs != 4 || got !== CT || lst !== 4'b1000) begin
         errors++; $display("FAIL bp_words: got %0d %h %b expected 4 %h 1000", nhs, got, lst, CT);
      end
      checks++;
      if (!srdy || !after) begin
         errors++; $display("FAIL bp_s_ready: got during=%b after=%b expected 1 1", srdy, after);
      end
   endtask

   task automatic test_timeout();
      bit ok1, ok2, stable, held, srdy, after;
      logic [127:0] d, k, got;
      logic dc;
      logic [3:0] lst;
      int nhs;
      err_clr = 1'b1;
      send_block(PT, 1'b0, -1, ok1);
      wait_start(ok2);
      mvalid_seen = 1'b0;
      repeat (16) @(negedge clk);
      checks++;
      if (timeout_err !== 1'b0 || !(ok1 && ok2)) begin
         errors++; $display("FAIL to_early: got %b expected 0", timeout_err);
      end
      @(negedge clk);
      checks++;
      if (timeout_err !== 1'b1) begin
         errors++; $display("FAIL to_set: got %b expected 1", timeout_err);
      end
      checks++;
      if (s_if.ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL to_abort: s_ready/busy got %b%b expected 10", s_if.ready, busy);
      end
      @(negedge clk);
      err_clr = 1'b0;
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++; $display("FAIL to_clear: got %b expected 0", timeout_err);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (mvalid_seen !== 1'b0) begin
         errors++; $display("FAIL to_no_output: got m_valid seen expected none");
      end
      send_block(PT, 1'b0, -1, ok1);
      serve_core(CT, ok2, d, k, dc, stable);
      drain(4'b1111, got, lst, nhs, held, srdy, after);
      checks++;
      if (got !== CT || nhs != 4 || !(ok1 && ok2)) begin
         errors++; $display("FAIL to_next_block: got %h/%0d expected %h/4", got, nhs, CT);
      end
   endtask

   task automatic test_reset_wait();
      bit ok1, ok2;
      int s0;
      send_block(PT, 1'b0, -1, ok1);
      wait_start(ok2);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({s_if.ready, m_if.valid, core_start, busy, timeout_err} !== 5'b0 ||
          core_data !== 128'h0 || core_key !== 128'h0 || !(ok1 && ok2)) begin
         errors++; $display("FAIL rw_async: got %b %h %h expected 00000 0 0", {s_if.ready,
                  m_if.valid, core_start, busy, timeout_err}, core_data, core_key);
      end
      @(negedge clk);
      rst = 1'b0;
      mvalid_seen = 1'b0;
      s0 = start_cnt;
      @(negedge clk);
      core_ready = 1'b1; core_result = CT;
      @(negedge clk);
      core_ready = 1'b0; core_result = '0;
      repeat (10) @(negedge clk);
      checks++;
      if (mvalid_seen !== 1'b0 || busy !== 1'b0 || start_cnt != s0) begin
         errors++; $display("FAIL rw_late_ready: mvalid/busy/starts got %b%b%0d expected 000",
                            mvalid_seen, busy, start_cnt - s0);
      end
      checks++;
      if (s_if.ready !== 1'b1 || timeout_err !== 1'b0 || m_if.data !== 32'h0) begin
         errors++; $display("FAIL rw_idle: got %b%b %h expected 10 0", s_if.ready, timeout_err,
                            m_if.data);
      end
   endtask

   initial begin
      rst = 1'b1; key_wr = 1'b0; key_data = '0; mode_dec = 1'b0;
      s_if.valid = 1'b0; s_if.data = '0; s_if.last = 1'b0; m_if.ready = 1'b0;
      core_ready = 1'b0; core_result = '0; err_clr = 1'b0;
      @(negedge clk);
      test_reset();
      test_encrypt();
      test_decrypt();
      test_backpressure();
      test_timeout();
      test_reset_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200us");
      $fatal(1);
   end

endmodule

// File: doc/aes_stream_adapter.md
AES_STREAM_ADAPTER -- requirements
Module: aes_stream_adapter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1023: max cycles spent in WAIT before abort.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 key_wr  in  1  one-cycle pulse, load key_data.
REQ-005 key_data  in  128  AES-128 key.
REQ-006 mode_dec  in  1  1=decrypt, 0=encrypt; sampled on first-word handshake.
REQ-007 s_valid / s_ready / s_data  in / out / in  1/1/32  input word stream.
REQ-008 m_valid / m_ready / m_data / m_last  out / in / out / out  1/1/32/1  output word stream.
REQ-009 core_start  out  1  start pulse to the AES core.
REQ-010 core_decrypt  out  1  mode to the core.
REQ-011 core_data / core_key  out  128 each  block and key to the core.
REQ-012 core_ready / core_result  in  1 / 128  core done pulse and result.
REQ-013 busy  out  1  high in any state other than COLLECT with zero words held.
REQ-014 timeout_err / err_clr  out / in  1 / 1  sticky abort flag and its clear.

Function
REQ-015 States SHALL be COLLECT, LAUNCH, WAIT, DRAIN.
REQ-016 COLLECT: s_ready=1; each s_valid&s_ready handshake stores one word, first word into core_data[127:96], fourth into [31:0].
REQ-017 mode_dec SHALL be latched into core_decrypt on the first-word handshake and held until the block leaves DRAIN or aborts.
REQ-018 Fourth handshake at cycle t -> LAUNCH at t+1, with core_start=1 for exactly cycle t+1; WAIT from t+2.
REQ-019 core_start SHALL be low for at least one cycle before every assertion, because the core edge-detects it.
REQ-020 core_data, core_key and core_decrypt SHALL be stable from LAUNCH until core_ready is seen in WAIT.
REQ-021 s_ready SHALL be 0 in LAUNCH, WAIT and DRAIN.
REQ-022 core_ready in WAIT -> capture core_result and enter DRAIN next cycle; core_ready in any other state is ignored.
REQ-023 DRAIN: m_valid=1, words emitted [127:96] first; m_data/m_last held while m_ready=0; m_last=1 on the fourth word only.
REQ-024 Fourth output handshake -> COLLECT next cycle with word count 0; no bubble beyond that one cycle.
REQ-025 The WAIT cycle counter SHALL clear on WAIT entry; reaching TIMEOUT_CYC sets timeout_err, discards the block, and returns to COLLECT with no output.
REQ-026 err_clr clears timeout_err; a simultaneous set and clear leaves it set.
REQ-027 key_wr SHALL take effect only in COLLECT with zero words held; otherwise it is ignored.

Reset
REQ-028 Asserting rst at any time (including mid-WAIT or mid-DRAIN) SHALL force COLLECT, word count 0, counters 0, and drop any partial or pending block.
REQ-029 Reset values: s_ready=0 (rising to 1 on the first clock after release), m_valid=0, m_last=0, m_data=0, core_start=0, core_decrypt=0, core_data=0, core_key=0, busy=0, timeout_err=0.

Structure
REQ-030 Package aes_stream_pkg SHALL hold the state encoding, the 2-bit word index type, and the TIMEOUT_CYC default.
REQ-031 Output serialisation SHALL live in one sub-module, aes_word_unpacker (128-bit load, 32-bit valid/ready out, last flag).

Verification
REQ-032 Encrypt, FIPS-197 vector:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f; words 00112233, 44556677, 8899aabb, ccddeeff; mode_dec=0.
  - Response: m_data 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; m_last on the fourth word.
REQ-033 Decrypt, same key:
  - Stimulus: the four ciphertext words above; mode_dec=1.
  - Response: the four plaintext words; core_start pulses once.
REQ-034 Backpressure:
  - Stimulus: m_ready toggles 1-0-0-1 during DRAIN.
  - Response: each word is held unchanged while stalled; exactly four handshakes; s_ready stays 0 until after the last one.
REQ-035 Timeout:
  - Stimulus: a stub core never asserts core_ready, with TIMEOUT_CYC=16.
  - Response: timeout_err=1 exactly 16 cycles after WAIT entry; no m_valid; the next block is processed normally.
REQ-036 Reset in WAIT:
  - Stimulus: rst pulsed mid-WAIT, then a late core_ready.
  - Response: the late core_ready is ignored; no output; all outputs take reset values.
